// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory access controller.
package dmem_pkg;

    localparam int LANE_W = 32;
    localparam int MEM_W  = 64;
    localparam int ADDR_W = 30;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RMW_WAIT,
        WR_COMMIT
    } state_t;

    // Pick one 32-bit lane out of a doubleword: lane 0 is the low half.
    function automatic logic [LANE_W-1:0] lane_select(input logic [MEM_W-1:0] dword,
                                                      input logic             lane);
        return lane ? dword[MEM_W-1:LANE_W] : dword[LANE_W-1:0];
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte merge: overlays enabled bytes of a 32-bit word onto
// the selected lane of a 64-bit doubleword, leaving every other byte intact.
module byte_lane_merge
    import dmem_pkg::*;
(
    input  logic [MEM_W-1:0]  old_data,
    input  logic              lane_sel,
    input  logic [3:0]        be,
    input  logic [LANE_W-1:0] new_data,
    output logic [MEM_W-1:0]  merged_data
);

    genvar gi;
    generate
        for (gi = 0; gi < MEM_W / 8; gi++) begin : g_byte
            // Byte gi of the doubleword belongs to lane gi/4, byte gi%4 of that lane.
            localparam logic BYTE_LANE = (gi >= 4);
            localparam int   BYTE_IDX  = gi % 4;
            assign merged_data[gi*8 +: 8] = (lane_sel == BYTE_LANE && be[BYTE_IDX])
                                            ? new_data[BYTE_IDX*8 +: 8]
                                            : old_data[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences 32-bit core loads/stores onto a 64-bit data-memory port.
// Loads pick one lane of the returned doubleword; every store is a
// read-modify-write of the containing doubleword.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [LANE_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [LANE_W-1:0] resp_rdata,
    output logic              mem_wen_D,
    output logic [ADDR_W-1:0] mem_addr_D,
    output logic [MEM_W-1:0]  mem_wdata_D,
    input  logic [MEM_W-1:0]  mem_rdata_D
);

    // Reload value makes the final wait cycle the one where the counter reads zero.
    localparam logic [1:0] CNT_RELOAD = 2'(READ_LAT - 1);

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               lane_q, lane_d;
    logic [3:0]         be_q, be_d;
    logic [LANE_W-1:0]  wdata_q, wdata_d;
    logic               resp_valid_q, resp_valid_d;
    logic [LANE_W-1:0]  resp_rdata_q, resp_rdata_d;
    logic               mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [MEM_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MEM_W-1:0]   merged_data;

    byte_lane_merge u_merge (
        .old_data    (mem_rdata_D),
        .lane_sel    (lane_q),
        .be          (be_q),
        .new_data    (wdata_q),
        .merged_data (merged_data)
    );

    // Next-state and registered-output decode; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lane_d       = lane_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_wen_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        req_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    lane_d     = req_addr[0];
                    be_d       = req_be;
                    wdata_d    = req_wdata;
                    mem_addr_d = {req_addr[ADDR_W-1:1], 1'b0};
                    cnt_d      = CNT_RELOAD;
                    state_d    = req_wen ? RMW_WAIT : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    resp_rdata_d = lane_select(mem_rdata_D, lane_q);
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RMW_WAIT: begin
                if (cnt_q == 2'd0) begin
                    // Write strobe and completion land together in WR_COMMIT.
                    mem_wdata_d  = merged_data;
                    mem_wen_d    = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    state_d      = WR_COMMIT;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            WR_COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            lane_q       <= 1'b0;
            be_q         <= 4'd0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lane_q       <= lane_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_wen_D   = mem_wen_q;
    assign mem_addr_D  = mem_addr_q;
    assign mem_wdata_D = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: two instances (READ_LAT 1 and 3) share a
// small doubleword memory whose read data is only correct in the cycle
// READ_LAT after the accept edge.
module tb_dmem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic        req_wen     [2];
    logic [29:0] req_addr    [2];
    logic [3:0]  req_be      [2];
    logic [31:0] req_wdata   [2];
    logic        resp_valid  [2];
    logic [31:0] resp_rdata  [2];
    logic        mem_wen_D   [2];
    logic [29:0] mem_addr_D  [2];
    logic [63:0] mem_wdata_D [2];
    logic [63:0] mem_rdata_D [2];

    logic [63:0] mem [16];
    logic [3:0]  age [2] = '{4'd15, 4'd15};
    int          wen_cnt [2] = '{0, 0};
    int          store_cnt [2] = '{0, 0};
    int unsigned cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    dmem_access_ctrl #(.READ_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .mem_wen_D(mem_wen_D[0]), .mem_addr_D(mem_addr_D[0]),
        .mem_wdata_D(mem_wdata_D[0]), .mem_rdata_D(mem_rdata_D[0])
    );

    dmem_access_ctrl #(.READ_LAT(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .mem_wen_D(mem_wen_D[1]), .mem_addr_D(mem_addr_D[1]),
        .mem_wdata_D(mem_wdata_D[1]), .mem_rdata_D(mem_rdata_D[1])
    );

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Memory: correct data only at age == READ_LAT, inverted data otherwise.
    assign mem_rdata_D[0] = (age[0] == 4'd1) ? mem[mem_addr_D[0][4:1]] : ~mem[mem_addr_D[0][4:1]];
    assign mem_rdata_D[1] = (age[1] == 4'd3) ? mem[mem_addr_D[1][4:1]] : ~mem[mem_addr_D[1][4:1]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i])
                age[i] <= 4'd1;
            else if (age[i] != 4'd15)
                age[i] <= age[i] + 4'd1;
            if (mem_wen_D[i])
                wen_cnt[i] <= wen_cnt[i] + 1;
        end
    end

    // Reference model: plain lane arithmetic on doublewords.
    function automatic logic [31:0] ref_lane(input logic [63:0] d, input logic s);
        return 32'(d >> (int'(s) * 32));
    endfunction

    function automatic logic [63:0] ref_merge(input logic [63:0] old, input logic s,
                                              input logic [3:0] be, input logic [31:0] wd);
        logic [63:0] m;
        m = '0;
        for (int j = 0; j < 4; j++)
            if (be[j]) m[int'(s)*32 + j*8 +: 8] = 8'hFF;
        return (old & ~m) | ((64'(wd) << (int'(s) * 32)) & m);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        else
            pass_cnt++;
    endtask

    // Issue one request at the current negedge and check every cycle until
    // completion; while the block is busy, junk requests are held valid.
    task automatic do_txn(input int i, input logic w, input logic [29:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp_r, input logic [63:0] exp_w,
                          output int unsigned t_acc);
        int l;
        int last;
        int waited;
        l = lat(i);
        last = w ? l + 2 : l + 1;
        req_valid[i] = 1'b1;
        req_wen[i]   = w;
        req_addr[i]  = a;
        req_be[i]    = be;
        req_wdata[i] = wd;
        waited = 0;
        while (!req_ready[i] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", 64'(req_ready[i]), 64'd1);
        t_acc = cyc;
        if (w) store_cnt[i]++;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            chk("mem_addr", 64'(mem_addr_D[i]), 64'({a[29:1], 1'b0}));
            chk("req_ready", 64'(req_ready[i]), 64'(k >= last));
            chk("resp_valid", 64'(resp_valid[i]), 64'(k == l + 1));
            chk("mem_wen", 64'(mem_wen_D[i]), 64'(w && (k == l + 1)));
            if (k == l + 1) begin
                chk("resp_rdata", 64'(resp_rdata[i]), 64'(exp_r));
                if (w) begin
                    chk("mem_wdata", mem_wdata_D[i], exp_w);
                    mem[a[4:1]] = mem_wdata_D[i];
                end
            end
            if (k < last) begin
                req_valid[i] = 1'b1;
                req_wen[i]   = 1'($urandom);
                req_addr[i]  = 30'($urandom);
                req_be[i]    = 4'($urandom);
                req_wdata[i] = $urandom;
            end
        end
        req_valid[i] = 1'b0;
        $display("txn lat%0d %s addr=%h be=%h wdata=%h t=%0d", l, w ? "st" : "ld", a, be, wd, t_acc);
    endtask

    typedef struct {
        logic        w;
        logic [29:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [63:0] old;
        logic [31:0] er;
        logic [63:0] ew;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int unsigned t1, t2, ta;
        int          di;
        logic        rw;
        logic [29:0] ra;
        logic [3:0]  rbe;
        logic [31:0] rwd;

        vecs[0] = '{1'b0, 30'h4,        4'b0000, 32'h0,         64'h1111_2222_3333_4444, 32'h3333_4444, 64'h0};
        vecs[1] = '{1'b0, 30'h5,        4'b0000, 32'h0,         64'h1111_2222_3333_4444, 32'h1111_2222, 64'h0};
        vecs[2] = '{1'b1, 30'h5,        4'b0011, 32'hAAAA_BBBB, 64'h1111_2222_3333_4444, 32'h0, 64'h1111_BBBB_3333_4444};
        vecs[3] = '{1'b1, 30'h4,        4'b0000, 32'hFFFF_FFFF, 64'h0123_4567_89AB_CDEF, 32'h0, 64'h0123_4567_89AB_CDEF};
        vecs[4] = '{1'b1, 30'h6,        4'b1111, 32'hDEAD_BEEF, 64'h5555_6666_7777_8888, 32'h0, 64'h5555_6666_DEAD_BEEF};
        vecs[5] = '{1'b1, 30'h3FFF_FFFF, 4'b1001, 32'h1234_5678, 64'h0,                  32'h0, 64'h1200_0078_0000_0000};

        for (int m = 0; m < 16; m++) mem[m] = {$urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_wen[i] = 1'b0; req_addr[i] = '0;
            req_be[i] = '0; req_wdata[i] = '0;
        end

        // Asynchronous reset, checked before any clock edge.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", 64'(req_ready[i]), 64'd1);
            chk("rst_resp_valid", 64'(resp_valid[i]), 64'd0);
            chk("rst_resp_rdata", 64'(resp_rdata[i]), 64'd0);
            chk("rst_mem_wen", 64'(mem_wen_D[i]), 64'd0);
            chk("rst_mem_addr", 64'(mem_addr_D[i]), 64'd0);
            chk("rst_mem_wdata", mem_wdata_D[i], 64'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors on the READ_LAT=1 instance.
        for (int v = 0; v < 6; v++) begin
            mem[vecs[v].a[4:1]] = vecs[v].old;
            do_txn(0, vecs[v].w, vecs[v].a, vecs[v].be, vecs[v].wd, vecs[v].er, vecs[v].ew, ta);
            @(negedge clk);
        end

        // Back-to-back loads, READ_LAT=3: accepts four cycles apart.
        do_txn(1, 1'b0, 30'h0ABC_DEF1, 4'h0, 32'h0, ref_lane(mem[4'h8], 1'b1), 64'h0, t1);
        do_txn(1, 1'b0, 30'h0000_0012, 4'h0, 32'h0, ref_lane(mem[4'h9], 1'b0), 64'h0, t2);
        chk("b2b_accept_gap", 64'(t2 - t1), 64'd4);

        // Randomized traffic on both instances.
        for (int n = 0; n < 120; n++) begin
            di  = int'($urandom_range(0, 1));
            rw  = 1'($urandom);
            ra  = 30'($urandom);
            rbe = 4'($urandom);
            rwd = $urandom;
            do_txn(di, rw, ra, rbe, rwd,
                   rw ? 32'h0 : ref_lane(mem[ra[4:1]], ra[0]),
                   ref_merge(mem[ra[4:1]], ra[0], rbe, rwd), ta);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // Reset during RMW_WAIT of a READ_LAT=3 store.
        do_txn(1, 1'b1, 30'h11, 4'hF, 32'h1357_9BDF, 32'h0,
               ref_merge(mem[4'h8], 1'b1, 4'hF, 32'h1357_9BDF), ta);
        req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 30'h2AAA_AAA7;
        req_be[1] = 4'b0101; req_wdata[1] = 32'hCAFE_F00D;
        chk("abort_accept_ready", 64'(req_ready[1]), 64'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("abort_busy_ready", 64'(req_ready[1]), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_req_ready", 64'(req_ready[1]), 64'd1);
        chk("abort_resp_valid", 64'(resp_valid[1]), 64'd0);
        chk("abort_resp_rdata", 64'(resp_rdata[1]), 64'd0);
        chk("abort_mem_wen", 64'(mem_wen_D[1]), 64'd0);
        chk("abort_mem_addr", 64'(mem_addr_D[1]), 64'd0);
        chk("abort_mem_wdata", mem_wdata_D[1], 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold_wen", 64'(mem_wen_D[1]), 64'd0);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_abort_ready", 64'(req_ready[1]), 64'd1);
            chk("post_abort_wen", 64'(mem_wen_D[1]), 64'd0);
            chk("post_abort_resp", 64'(resp_valid[1]), 64'd0);
        end

        // One write pulse per completed store, none for loads or the aborted store.
        chk("wen_pulses_lat1", 64'(wen_cnt[0]), 64'(store_cnt[0]));
        chk("wen_pulses_lat3", 64'(wen_cnt[1]), 64'(store_cnt[1]));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
